// File: rtl/pattern_ctrl_pkg.sv
// Shared types and seed helpers for the n-bit pattern sequencing controller.
// Contents:
//   mode_t  - pattern family selected by a command (BINARY/RING/JOHNSON/GRAY)
//   state_t - controller FSM states (IDLE/RUN/DONE)
//   seed_q  - first pattern value of a command, for any width n (cast to n bits)
//   seed_b  - starting value of the internal binary count used by GRAY
package pattern_ctrl_pkg;

  typedef enum logic [1:0] {
    BINARY  = 2'd0,
    RING    = 2'd1,
    JOHNSON = 2'd2,
    GRAY    = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Seeds are produced at the widest supported width; callers size-cast to n.
  localparam int unsigned SEED_W = 64;

  // RING starts with a single hot bit in the LSB; every other family starts at 0.
  function automatic logic [SEED_W-1:0] seed_q(input mode_t mode);
    return (mode == RING) ? SEED_W'(1) : '0;
  endfunction

  function automatic logic [SEED_W-1:0] seed_b();
    return '0;
  endfunction

endpackage

// File: rtl/pattern_step.sv
// Combinational single-step advance for the n-bit pattern families.
// Ports:
//   mode  - pattern family
//   q     - current pattern value
//   b     - current internal binary count (only meaningful for GRAY)
//   q_nxt - next pattern value
//   b_nxt - next internal binary count (held for non-GRAY modes)
module pattern_step
  import pattern_ctrl_pkg::*;
#(
  parameter int n = 4
) (
  input  mode_t          mode,
  input  logic [n-1:0]   q,
  input  logic [n-1:0]   b,
  output logic [n-1:0]   q_nxt,
  output logic [n-1:0]   b_nxt
);

  always_comb begin
    q_nxt = q;
    b_nxt = b;
    case (mode)
      BINARY:  q_nxt = q + n'(1);
      RING:    q_nxt = {q[0], q[n-1:1]};
      JOHNSON: q_nxt = {~q[0], q[n-1:1]};
      GRAY: begin
        // Gray output is derived from a hidden binary count so that the
        // sequence is exact even across wrap-around.
        b_nxt = b + n'(1);
        q_nxt = b_nxt ^ (b_nxt >> 1);
      end
      default: q_nxt = q;
    endcase
  end

endmodule

// File: rtl/nbit_pattern_ctrl.sv
// Command-driven sequencer for n-bit pattern counters (binary, ring, Johnson,
// Gray). One command at a time is accepted via cmd_valid/cmd_ready; the
// controller then emits exactly cmd_len pattern values, one per unpaused
// cycle, followed by a one-cycle done pulse.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   cmd_valid/ready   - command handshake (ready only in IDLE)
//   cmd_mode, cmd_len - pattern family and number of values to emit
//   pause, abort      - stream freeze / early termination (RUN only)
//   q, q_valid        - pattern value and new-element strobe
//   busy              - command in progress (RUN or DONE)
//   done, aborted     - end-of-command pulse and its abort qualifier
module nbit_pattern_ctrl
  import pattern_ctrl_pkg::*;
#(
  parameter int n  = 4,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_mode,
  input  logic [LW-1:0] cmd_len,
  input  logic          pause,
  input  logic          abort,
  output logic [n-1:0]  q,
  output logic          q_valid,
  output logic          busy,
  output logic          done,
  output logic          aborted
);

  state_t        state, state_nxt;
  mode_t         mode_r, mode_nxt;
  logic [LW-1:0] rem_r, rem_nxt;
  logic [n-1:0]  b_r, b_nxt;
  logic [n-1:0]  q_nxt;
  logic          q_valid_nxt, done_nxt, aborted_nxt;
  logic [n-1:0]  step_q, step_b;
  mode_t         cmd_mode_t;

  assign cmd_mode_t = mode_t'(cmd_mode);
  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);

  pattern_step #(.n(n)) u_step (
    .mode  (mode_r),
    .q     (q),
    .b     (b_r),
    .q_nxt (step_q),
    .b_nxt (step_b)
  );

  always_comb begin
    state_nxt   = state;
    mode_nxt    = mode_r;
    rem_nxt     = rem_r;
    b_nxt       = b_r;
    q_nxt       = q;
    q_valid_nxt = 1'b0;
    done_nxt    = 1'b0;
    aborted_nxt = 1'b0;
    case (state)
      IDLE: begin
        // cmd_ready is high throughout IDLE, so cmd_valid alone accepts.
        if (cmd_valid) begin
          mode_nxt = cmd_mode_t;
          if (cmd_len == '0) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt   = RUN;
            q_nxt       = n'(seed_q(cmd_mode_t));
            b_nxt       = n'(seed_b());
            q_valid_nxt = 1'b1;
            // The seed counts as the first element.
            rem_nxt     = cmd_len - LW'(1);
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt   = DONE;
          done_nxt    = 1'b1;
          aborted_nxt = 1'b1;
        end else if (pause) begin
          state_nxt = RUN;
        end else if (rem_r == '0) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else begin
          q_nxt       = step_q;
          b_nxt       = step_b;
          q_valid_nxt = 1'b1;
          rem_nxt     = rem_r - LW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control and visible outputs: reset to their idle values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      q_valid <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= state_nxt;
      q       <= q_nxt;
      q_valid <= q_valid_nxt;
      done    <= done_nxt;
      aborted <= aborted_nxt;
    end
  end

  // Command context: always reloaded on acceptance before it is used.
  always_ff @(posedge clk) begin
    mode_r <= mode_nxt;
    rem_r  <= rem_nxt;
    b_r    <= b_nxt;
  end

endmodule

// File: tb/tb_nbit_pattern_ctrl.sv
module tb_nbit_pattern_ctrl;
  localparam int N  = 4;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_mode = 2'd0;
  logic [LW-1:0] cmd_len = '0;
  logic          pause = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  q;
  logic          q_valid, busy, done, aborted;

  always #5 clk = ~clk;

  nbit_pattern_ctrl #(.n(N), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_len   (cmd_len),
    .pause     (pause),
    .abort     (abort),
    .q         (q),
    .q_valid   (q_valid),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  // i-th element of a stream (seed is i=0), in closed form.
  function automatic logic [N-1:0] pat(input logic [1:0] mode, input int i);
    int k;
    int g;
    case (mode)
      2'd0: return N'(i % (1 << N));
      2'd1: return N'(1 << ((N - (i % N)) % N));
      2'd2: begin
        k = i % (2 * N);
        if (k <= N) return N'(((1 << k) - 1) << (N - k));
        else        return N'((1 << (2 * N - k)) - 1);
      end
      default: begin
        g = i % (1 << N);
        return N'(g ^ (g >> 1));
      end
    endcase
  endfunction

  // Reference model: 0 idle, 1 streaming, 2 ending.
  int           m_st = 0;
  logic [1:0]   m_mode = 2'd0;
  int           m_len = 0;
  int           m_idx = 0;
  logic [N-1:0] m_q = '0;
  logic         m_qv = 1'b0, m_done = 1'b0, m_ab = 1'b0;
  bit           m_init = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_init <= 1'b1;
      m_st   <= 0;
      m_q    <= '0;
      m_qv   <= 1'b0;
      m_done <= 1'b0;
      m_ab   <= 1'b0;
    end else begin
      m_qv   <= 1'b0;
      m_done <= 1'b0;
      m_ab   <= 1'b0;
      case (m_st)
        0: if (cmd_valid) begin
          if (cmd_len == 0) begin
            m_st   <= 2;
            m_done <= 1'b1;
          end else begin
            m_st   <= 1;
            m_mode <= cmd_mode;
            m_len  <= int'(cmd_len);
            m_idx  <= 1;
            m_q    <= pat(cmd_mode, 0);
            m_qv   <= 1'b1;
          end
        end
        1: begin
          if (abort) begin
            m_st   <= 2;
            m_done <= 1'b1;
            m_ab   <= 1'b1;
          end else if (pause) begin
            m_st <= 1;
          end else if (m_idx == m_len) begin
            m_st   <= 2;
            m_done <= 1'b1;
          end else begin
            m_q   <= pat(m_mode, m_idx);
            m_idx <= m_idx + 1;
            m_qv  <= 1'b1;
          end
        end
        default: m_st <= 0;
      endcase
    end
  end

  // Compare process: model on every cycle, hand-written element lists on done.
  int           checks = 0;
  int           passes = 0;
  logic [N-1:0] cap[$];
  logic [N-1:0] lit[$];
  logic         lit_ab = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m_init) begin
      chk("q",         32'(q),         32'(m_q));
      chk("q_valid",   32'(q_valid),   32'(m_qv));
      chk("done",      32'(done),      32'(m_done));
      chk("aborted",   32'(aborted),   32'(m_ab));
      chk("busy",      32'(busy),      32'(m_st != 0));
      chk("cmd_ready", 32'(cmd_ready), 32'(m_st == 0));
      if (q_valid) cap.push_back(q);
      if (done) begin
        chk("elem_count", 32'(cap.size()), 32'(lit.size()));
        for (int i = 0; i < cap.size() && i < lit.size(); i++)
          chk("elem", 32'(cap[i]), 32'(lit[i]));
        chk("aborted_lit", 32'(aborted), 32'(lit_ab));
        cap.delete();
      end
      if (rst) cap.delete();
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!cmd_ready) begin
      t++;
      if (t > 200) begin
        $display("FAIL cmd_ready_timeout: got 0 expected 1");
        $fatal(1);
      end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic [1:0] m, input int len);
    @(posedge clk); #1;
    cmd_mode  = m;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    wait_ready();
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_elems(input int k);
    int seen = 0;
    int t = 0;
    while (seen < k) begin
      @(negedge clk);
      if (q_valid) seen++;
      t++;
      if (t > 200) begin
        $display("FAIL elem_timeout: got %0d expected %0d", seen, k);
        $fatal(1);
      end
    end
  endtask

  task automatic wait_done();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
      if (t > 200) begin
        $display("FAIL done_timeout: got 0 expected 1");
        $fatal(1);
      end
    end while (!done);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // BINARY len 3
    send(2'd0, 3);
    lit = '{4'b0000, 4'b0001, 4'b0010}; lit_ab = 1'b0;
    wait_done();

    // RING len 6
    send(2'd1, 6);
    lit = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000}; lit_ab = 1'b0;
    wait_done();

    // JOHNSON len 9
    send(2'd2, 9);
    lit = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
            4'b0111, 4'b0011, 4'b0001, 4'b0000};
    lit_ab = 1'b0;
    wait_done();

    // GRAY len 5 with a two-cycle pause after the 2nd element
    send(2'd3, 5);
    lit = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110}; lit_ab = 1'b0;
    wait_elems(2);
    pause = 1'b1;
    @(negedge clk);
    @(negedge clk);
    pause = 1'b0;
    wait_done();

    // BINARY len 20 (wraps)
    send(2'd0, 20);
    lit.delete();
    for (int i = 0; i < 20; i++) lit.push_back(N'(i % 16));
    lit_ab = 1'b0;
    wait_done();

    // RING len 10, abort after 3rd element
    send(2'd1, 10);
    lit = '{4'b0001, 4'b1000, 4'b0100}; lit_ab = 1'b1;
    wait_elems(3);
    abort = 1'b1;
    wait_done();
    abort = 1'b0;

    // len 0
    send(2'd0, 0);
    lit.delete(); lit_ab = 1'b0;
    wait_done();

    // JOHNSON len 8, reset during the 4th element with next command held
    send(2'd2, 8);
    lit = '{4'b0000, 4'b0001}; lit_ab = 1'b0;
    wait_elems(3);
    @(posedge clk); #1;
    rst       = 1'b1;
    cmd_mode  = 2'd0;
    cmd_len   = LW'(2);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
